// File: rtl/arbiter_rr_sync.sv
// Registered round-robin arbiter: shares one four-phase req/ack channel among input_size requesters.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module arbiter_rr_sync #(
    parameter int input_size = 8
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [input_size-1:0] req_in,
    output logic [input_size-1:0] ack_in,
    output logic                  req_out,
    input  logic                  ack_out,
`ifdef ARB_TIMEOUT_EN
    output logic                  err_timeout,
`endif
    output logic [input_size-1:0] sel
);

    localparam int PW = (input_size > 1) ? $clog2(input_size) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [PW-1:0]           ptr_reg, ptr_next;
    logic [PW-1:0]           g_reg, g_next;
    logic [input_size-1:0]   sel_reg, sel_next;
    logic [input_size-1:0]   ack_reg, ack_next;
    logic                    req_out_reg, req_out_next;

    logic                    pick_valid;
    logic [PW-1:0]           pick_idx;
    logic [PW-1:0]           ptr_after_g;

    // Scan from ptr upward with wrap; iterating downward lets the lowest offset win.
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = input_size - 1; k >= 0; k--) begin
            idx = (int'(ptr_reg) + k) % input_size;
            if (req_in[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    assign ptr_after_g = (g_reg == PW'(input_size - 1)) ? '0 : g_reg + PW'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          err_reg, err_next;
    assign err_timeout = err_reg;
`endif

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        g_next       = g_reg;
        sel_next     = sel_reg;
        ack_next     = ack_reg;
        req_out_next = req_out_reg;
`ifdef ARB_TIMEOUT_EN
        cnt_next     = cnt_reg;
        err_next     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    g_next           = pick_idx;
                    sel_next         = '0;
                    sel_next[pick_idx] = 1'b1;
                    req_out_next     = 1'b1;
                    state_next       = GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_next         = '0;
`endif
                end
            end
            GRANT: begin
                // A stale ack_out already high on entry is accepted as the handshake.
                if (ack_out) begin
                    req_out_next = 1'b0;
                    ack_next     = sel_reg;
                    state_next   = RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    req_out_next = 1'b0;
                    sel_next     = '0;
                    ptr_next     = ptr_after_g;
                    err_next     = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
`endif
            end
            RELEASE: begin
                if (!req_in[g_reg] && !ack_out) begin
                    ack_next   = '0;
                    sel_next   = '0;
                    ptr_next   = ptr_after_g;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                sel_next     = '0;
                ack_next     = '0;
                req_out_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            g_reg       <= '0;
            sel_reg     <= '0;
            ack_reg     <= '0;
            req_out_reg <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            g_reg       <= g_next;
            sel_reg     <= sel_next;
            ack_reg     <= ack_next;
            req_out_reg <= req_out_next;
`ifdef ARB_TIMEOUT_EN
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
`endif
        end
    end

    assign sel     = sel_reg;
    assign ack_in  = ack_reg;
    assign req_out = req_out_reg;

endmodule
